testport_writer: RTL and testbench



---
 rtl/testport_writer.sv | 225 ++++++++++++++++++++++
 tb/tb_testport_writer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/testport_writer.sv
// testport_writer: bus-side stimulus initiator for the test-port protocol.
// On a start pulse it writes BEGIN_SYM, 32 mirrored Fibonacci values
// (0..610, 610..0) and END_SYM to word address TEST_PORT. Each write holds
// wen/addr/data until accepted (wen=1 and mem_stall=0 at a rising edge), then
// drops wen for GAP_CYCLES cycles. Data goes out byte-swapped (little-endian).
//
// Optional feature: define TESTPORT_ERR_INJECT_EN to emit the value at index
// ERR_IDX with bit 0 inverted. The generator registers stay exact, so only that
// single word is wrong. Without the macro no injection logic exists.
module testport_writer #(
    parameter logic [29:0] TEST_PORT  = 30'hFF,
    parameter logic [31:0] BEGIN_SYM  = 32'h00000168,
    parameter logic [31:0] END_SYM    = 32'hFFFFFD5D,
    parameter int          GAP_CYCLES = 1,
    parameter int          ERR_IDX    = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mem_stall,
    output logic [29:0] addr,
    output logic [31:0] data,
    output logic        wen,
    output logic        busy,
    output logic        done,
    output logic [5:0]  write_cnt
);

    // Out-of-range parameters would silently break the gap counter or the
    // 5-bit index compare, so refuse to elaborate with them.
    if (GAP_CYCLES < 1 || GAP_CYCLES > 7) begin : g_gap_range
        $error("testport_writer: GAP_CYCLES must be 1..7");
    end
    if (ERR_IDX < 0 || ERR_IDX > 31) begin : g_err_idx_range
        $error("testport_writer: ERR_IDX must be 0..31");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_GAP   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Which item is pending: the begin symbol, a generator value, or the end symbol.
    typedef enum logic [1:0] {
        PH_BEGIN = 2'd0,
        PH_VALUE = 2'd1,
        PH_END   = 2'd2
    } phase_t;

    // The counter is loaded on acceptance and the GAP state exits when it reads 0,
    // which gives exactly GAP_CYCLES cycles with wen low.
    localparam logic [2:0] GAP_LOAD = 3'(GAP_CYCLES - 1);

    // Bus byte order: least significant byte of the logical word first.
    function automatic logic [31:0] bswap(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    state_t      state_q, state_d;
    phase_t      phase_q, phase_d;
    logic [4:0]  idx_q, idx_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [2:0]  gap_cnt_q, gap_cnt_d;
    logic [29:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        wen_q, wen_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [5:0]  write_cnt_q, write_cnt_d;

    logic [31:0] value_word;
    logic [31:0] item_word;

    // Logical value for the current index, with the optional single-bit corruption.
`ifdef TESTPORT_ERR_INJECT_EN
    localparam logic [4:0] ERR_IDX5 = 5'(ERR_IDX);
    always_comb begin
        value_word = a_q;
        if (idx_q == ERR_IDX5) begin
            value_word = a_q ^ 32'd1;
        end
    end
`else
    always_comb begin
        value_word = a_q;
    end
`endif

    // Logical word of the pending item, selected by phase.
    always_comb begin
        item_word = END_SYM;
        case (phase_q)
            PH_BEGIN: item_word = BEGIN_SYM;
            PH_VALUE: item_word = value_word;
            default:  item_word = END_SYM;
        endcase
    end

    // Next-state logic for the FSM, the registered outputs and the generator.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        idx_d       = idx_q;
        a_d         = a_q;
        b_d         = b_q;
        gap_cnt_d   = gap_cnt_q;
        addr_d      = addr_q;
        data_d      = data_q;
        wen_d       = wen_q;
        busy_d      = busy_q;
        done_d      = done_q;
        write_cnt_d = write_cnt_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                // start wins over mem_stall here; the stall only matters in WRITE.
                if (start) begin
                    state_d     = S_WRITE;
                    phase_d     = PH_BEGIN;
                    idx_d       = 5'd0;
                    wen_d       = 1'b1;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    write_cnt_d = 6'd0;
                    addr_d      = TEST_PORT;
                    data_d      = bswap(BEGIN_SYM);
                end
            end

            S_WRITE: begin
                // wen/addr/data simply hold while the bus stalls.
                if (!mem_stall) begin
                    write_cnt_d = write_cnt_q + 6'd1;
                    wen_d       = 1'b0;
                    if (phase_q == PH_END) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = S_GAP;
                        gap_cnt_d = GAP_LOAD;
                        if (phase_q == PH_BEGIN) begin
                            phase_d = PH_VALUE;
                            idx_d   = 5'd0;
                            a_d     = 32'd0;
                            b_d     = 32'd1;
                        end else if (idx_q == 5'd31) begin
                            phase_d = PH_END;
                        end else begin
                            idx_d = idx_q + 5'd1;
                            if (idx_q < 5'd15) begin
                                // Rising half: forward Fibonacci step.
                                a_d = b_q;
                                b_d = a_q + b_q;
                            end else if (idx_q > 5'd15) begin
                                // Falling half: step the recurrence backwards.
                                a_d = b_q - a_q;
                                b_d = a_q;
                            end
                            // idx 15 holds so 610 is emitted twice at the peak.
                        end
                    end
                end
            end

            S_GAP: begin
                // mem_stall is irrelevant here; only the gap counter matters.
                if (gap_cnt_q == 3'd0) begin
                    state_d = S_WRITE;
                    wen_d   = 1'b1;
                    addr_d  = TEST_PORT;
                    data_d  = bswap(item_word);
                end else begin
                    gap_cnt_d = gap_cnt_q - 3'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops wen immediately and parks in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            phase_q     <= PH_BEGIN;
            idx_q       <= 5'd0;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            gap_cnt_q   <= 3'd0;
            addr_q      <= 30'd0;
            data_q      <= 32'd0;
            wen_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            write_cnt_q <= 6'd0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            gap_cnt_q   <= gap_cnt_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            wen_q       <= wen_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            write_cnt_q <= write_cnt_d;
        end
    end

    assign addr      = addr_q;
    assign data      = data_q;
    assign wen       = wen_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign write_cnt = write_cnt_q;

endmodule

// File: tb/tb_testport_writer.sv
// tb_testport_writer: self-checking bench for testport_writer.
// A table of run descriptors (stall position/length, extra start pulses,
// expected busy length) is applied in a loop; a scoreboard queue holds the
// expected bus words and is popped by a monitor on each accepted write.
// Hand-written sequences cover reset values and reset in the middle of a run.
module tb_testport_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mem_stall;
    logic [29:0] addr;
    logic [31:0] data;
    logic        wen;
    logic        busy;
    logic        done;
    logic [5:0]  write_cnt;

    always #5 clk = ~clk;

    testport_writer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mem_stall (mem_stall),
        .addr      (addr),
        .data      (data),
        .wen       (wen),
        .busy      (busy),
        .done      (done),
        .write_cnt (write_cnt)
    );

    int checks = 0;
    int errors = 0;
    int acc_count = 0;
    int busy_cycles = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        int stall_item;       // item number (0=BEGIN .. 33=END) to stall, -1 none
        int stall_len;        // stall cycles on that item
        bit stall_with_start; // mem_stall asserted in the same cycle as start
        int extra_start;      // loop cycle for a start pulse while busy, -1 none
        int exp_busy;         // expected busy-high cycles
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] bswap(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    // Reference values: plain Fibonacci table, mirrored about index 15/16.
    function automatic logic [31:0] ref_value(input int i);
        logic [31:0] f[16];
        logic [31:0] v;
        f[0] = 32'd0;
        f[1] = 32'd1;
        for (int k = 2; k < 16; k++) f[k] = f[k-1] + f[k-2];
        v = (i < 16) ? f[i] : f[31 - i];
`ifdef TESTPORT_ERR_INJECT_EN
        if (i == 5) v = v ^ 32'd1;
`endif
        return v;
    endfunction

    function automatic logic [31:0] ref_word(input int n);
        if (n == 0)  return 32'h68010000;
        if (n == 33) return 32'h5DFDFFFF;
        return bswap(ref_value(n - 1));
    endfunction

    task automatic fill_scoreboard();
        exp_q.delete();
        for (int n = 0; n < 34; n++) exp_q.push_back(ref_word(n));
    endtask

    // Monitor: checks every wen-high cycle against the scoreboard head and pops on acceptance.
    initial begin
        bit prev_accept;
        prev_accept = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_accept = 1'b0;
            end else begin
                if (busy) busy_cycles++;
                if (prev_accept) chk("wen_low_after_accept", 32'(wen), 32'd0);
                if (wen) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: got data 0x%08h, expected no write", data);
                    end else begin
                        chk("write_data", data, exp_q[0]);
                        chk("write_addr", 32'(addr), 32'h000000FF);
                        if (!mem_stall) begin
                            $display("write %0d accepted: addr=0x%0h data=0x%08h", acc_count, addr, data);
                            void'(exp_q.pop_front());
                            acc_count++;
                        end
                    end
                end
                prev_accept = wen && !mem_stall;
            end
        end
    end

    task automatic drive_stall(input vec_t v, inout int stall_left);
        if (wen && acc_count == v.stall_item && stall_left > 0) begin
            mem_stall = 1'b1;
            stall_left--;
        end else begin
            mem_stall = 1'b0;
        end
    endtask

    task automatic run_vec(input int vi);
        vec_t v;
        int   stall_left;
        bit   finished;
        v = vecs[vi];
        stall_left = v.stall_len;
        finished = 1'b0;
        @(posedge clk); #1;
        fill_scoreboard();
        acc_count   = 0;
        busy_cycles = 0;
        start     = 1'b1;
        mem_stall = v.stall_with_start;
        @(posedge clk); #1;
        start = 1'b0;
        drive_stall(v, stall_left);
        @(negedge clk); #1;
        chk("first_wen", 32'(wen), 32'd1);
        chk("first_data", data, 32'h68010000);
        chk("first_write_cnt", 32'(write_cnt), 32'd0);
        chk("first_done", 32'(done), 32'd0);
        chk("first_busy", 32'(busy), 32'd1);
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(posedge clk); #1;
            if (done && !busy) begin
                finished = 1'b1;
                break;
            end
            start = (cyc == v.extra_start);
            drive_stall(v, stall_left);
        end
        start     = 1'b0;
        mem_stall = 1'b0;
        chk("seq_finished", 32'(finished), 32'd1);
        chk("busy_cycles", 32'(busy_cycles), 32'(v.exp_busy));
        chk("final_write_cnt", 32'(write_cnt), 32'd34);
        chk("final_done", 32'(done), 32'd1);
        chk("accepted_writes", 32'(acc_count), 32'd34);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        chk("final_wen", 32'(wen), 32'd0);
        $display("run %0d complete: writes=%0d busy_cycles=%0d", vi, acc_count, busy_cycles);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_addr"}, 32'(addr), 32'd0);
        chk({tag, "_data"}, data, 32'd0);
        chk({tag, "_wen"}, 32'(wen), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_write_cnt"}, 32'(write_cnt), 32'd0);
    endtask

    initial begin
        vecs[0] = '{stall_item: -1, stall_len: 0, stall_with_start: 1'b0, extra_start: 10, exp_busy: 67};
        vecs[1] = '{stall_item: 8,  stall_len: 3, stall_with_start: 1'b0, extra_start: -1, exp_busy: 70};
        vecs[2] = '{stall_item: 0,  stall_len: 1, stall_with_start: 1'b1, extra_start: -1, exp_busy: 68};
        vecs[3] = '{stall_item: 33, stall_len: 2, stall_with_start: 1'b0, extra_start: -1, exp_busy: 69};

        rst = 1'b1;
        start = 1'b0;
        mem_stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("in_reset");
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("after_reset");

        // Full run from IDLE (with an ignored start while busy), then a restart from DONE.
        run_vec(0);
        run_vec(1);

        // Reset in the gap after value 10 (12th acceptance).
        begin
            bit reached;
            reached = 1'b0;
            @(posedge clk); #1;
            fill_scoreboard();
            acc_count = 0;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            for (int cyc = 0; cyc < 200; cyc++) begin
                @(posedge clk); #1;
                if (acc_count == 12 && !wen) begin
                    reached = 1'b1;
                    break;
                end
            end
            chk("reached_gap_after_v10", 32'(reached), 32'd1);
            chk("pre_reset_write_cnt", 32'(write_cnt), 32'd12);
            chk("pre_reset_busy", 32'(busy), 32'd1);
            #1 rst = 1'b1;
            #1;
            check_reset_values("mid_reset");
            #1 rst = 1'b0;
            exp_q.delete();
            $display("reset applied in gap after value 10");
            repeat (4) @(posedge clk);
            #1;
            check_reset_values("no_resume");
        end

        // Restart from IDLE after reset, including start+stall in the same cycle.
        run_vec(2);
        run_vec(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
